proc_ctrl_fsm: RTL and testbench
================================

// Module: proc_ctrl_fsm
// PURPOSE
//  Control unit of the simple processor. Sequences the datapath: regi (IR),
//  eight regn (R0-R7), A, G, the adder/subtractor and the shared 16-bit bus mux.
//  Decodes IR = {III,XXX,YYY} and drives the register enables and bus selects
//  over 2-4 timesteps (T0-T3) per instruction.
//  Raises Done in the last step of each instruction.
// PARAMETERS
//  IR_W   9  instruction width {op[8:6], rx[5:3], ry[2:0]}; fixed, do not override
//  NREG   8  number of general registers; sets the width of Rin/Rout (one-hot)
// PORTS
//  Clock   in   1     system clock, rising edge
//  Resetn  in   1     asynchronous active-low reset
//  Run     in   1     start request; sampled only in T0
//  IR      in   9     Q of the instruction register (regi)
//  Gnz     in   1     G != 0; used only with CTRL_MVNZ_EN
//  IRin    out  1     IR load enable
//  Rin     out  NREG  one-hot register load enables
//  Rout    out  NREG  one-hot bus select, register source
//  Gout    out  1     bus select, G
//  DINout  out  1     bus select, DIN (immediate)
//  Ain     out  1     A load enable
//  Gin     out  1     G load enable
//  AddSub  out  1     0 = add, 1 = subtract
//  Done    out  1     last cycle of the instruction
//  Busy    out  1     state != T0
// BEHAVIOUR
//  One clock. Reset is asynchronous and active-low: Resetn=0 forces state T0 immediately.
//  - While Resetn=0 every output is 0, including IRin.
//  - State register is 2 bits: T0..T3. All outputs are combinational from the
//    registered state, IR and Run. No output is registered.
//  - T0: IRin=Run. Run=1 -> T1. Run=0 -> stay in T0, all outputs 0.
//  - T1 (decode op=IR[8:6], X=IR[5:3], Y=IR[2:0]):
//      000 mv  : Rout[Y]=1, Rin[X]=1, Done=1 -> T0
//      001 mvi : DINout=1, Rin[X]=1, Done=1 -> T0 (DIN must hold the immediate in T1)
//      010 add : Rout[X]=1, Ain=1 -> T2
//      011 sub : Rout[X]=1, Ain=1 -> T2
//      110 mvnz: see CONFIGURATION
//      others  : NOP. Done=1, no enables -> T0
//  - T2 (add/sub): Rout[Y]=1, Gin=1, AddSub=op[0] -> T3
//  - T3 (add/sub): Gout=1, Rin[X]=1, Done=1 -> T0
//  - Latency: mv/mvi/NOP take 2 cycles (T0,T1); add/sub take 4 cycles (T0..T3).
//    Back-to-back: Run held high re-fetches in the T0 right after Done.
//  - Invariants, every cycle: at most one of {Rout[*], Gout, DINout} is 1;
//    Rin has at most one bit set; Done=1 only in the step whose next state is T0.
//  - Run is ignored in T1-T3. IR must stay stable from T1 through Done.
//  - X==Y is legal: add R1,R1 doubles R1.
//  - Reset mid-instruction: the state returns to T0 at once and no Rin/Gin pulse
//    completes. Datapath registers keep their contents; the aborted write does not occur.
//  - Illegal/unreachable state encodings are not possible: the 2-bit state is fully decoded.
// CONFIGURATION
//  `define CTRL_MVNZ_EN
//   defined: op 110 = mvnz Rx,Ry in T1. If Gnz=1: Rout[Y]=1, Rin[X]=1.
//            If Gnz=0: no enables. Either way Done=1 -> T0.
//   undefined: op 110 decodes as NOP; the Gnz input is unused.
// TESTING
//  1 Reset: Resetn=0 while in T2 with Run=1 -> state T0 at once, all outputs 0;
//    after release with Run=0, outputs stay 0.
//  2 mvi R0,#5: IR=9'b001_000_000, DIN=16'h0005 -> T1: DINout=1, Rin=8'h01, Done=1; R0=5.
//  3 mv R3,R0: IR=9'b000_011_000 -> T1: Rout=8'h01, Rin=8'h08, Done=1; R3=5.
//  4 add R0,R3: IR=9'b010_000_011 -> T1 Ain with Rout=8'h01; T2 Gin with Rout=8'h08,
//    AddSub=0; T3 Gout, Rin=8'h01, Done; R0=10.
//    sub R0,R0 -> R0=0; check AddSub=1 in T2.
//  5 Run held high over mvi then sub -> Done pulses one cycle each; no idle gap
//    beyond T0; bus one-hot check holds every cycle.
//  6 IR op=110: with CTRL_MVNZ_EN, Gnz=1 copies Ry->Rx and Gnz=0 leaves Rx unchanged;
//    without the macro, op=110 is a NOP. Each case: Done in T1, 2-cycle latency.

Source files
------------

// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm
// Control unit of the simple processor. Steps through T0..T3 and drives the
// register-file, A, G and bus-mux controls for each decoded instruction.
// All outputs are combinational from the registered step, IR and Run.
// Optional feature macro: CTRL_MVNZ_EN (op 110 = mvnz; otherwise op 110 is a NOP).
module proc_ctrl_fsm #(
    parameter int IR_W = 9,
    parameter int NREG = 8
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Run,
    input  logic [IR_W-1:0] IR,
    input  logic            Gnz,
    output logic            IRin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Gout,
    output logic            DINout,
    output logic            Ain,
    output logic            Gin,
    output logic            AddSub,
    output logic            Done,
    output logic            Busy
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    step_t      r_state;
    step_t      w_next;
    logic [2:0] w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;

    assign w_op = IR[8:6];
    assign w_x  = IR[5:3];
    assign w_y  = IR[2:0];

`ifndef CTRL_MVNZ_EN
    // Gnz only matters for mvnz; keep it tied off so it is visibly unused.
    logic w_gnz_unused;
    assign w_gnz_unused = Gnz;
`endif

    // One-hot decode of a register index onto the NREG-wide enable vectors.
    function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
        logic [NREG-1:0] w_one;
        w_one = {{(NREG-1){1'b0}}, 1'b1};
        return w_one << idx;
    endfunction

    // Step register; reset drops straight back to T0 so no write can complete.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= T0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-step selection: add/sub run T0..T3, everything else ends in T1.
    always_comb begin
        w_next = T0;
        case (r_state)
            T0: begin
                if (Run) begin
                    w_next = T1;
                end else begin
                    w_next = T0;
                end
            end
            T1: begin
                if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
                    w_next = T2;
                end else begin
                    w_next = T0;
                end
            end
            T2:      w_next = T3;
            T3:      w_next = T0;
            default: w_next = T0;
        endcase
    end

    // Control outputs for the current step; at most one bus source per step.
    always_comb begin
        IRin   = 1'b0;
        Rin    = {NREG{1'b0}};
        Rout   = {NREG{1'b0}};
        Gout   = 1'b0;
        DINout = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        Busy   = (r_state != T0);
        case (r_state)
            T0: begin
                // Gate with Resetn so IRin cannot pulse while reset is held.
                IRin = Run & Resetn;
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        Rout = onehot(w_y);
                        Rin  = onehot(w_x);
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = onehot(w_x);
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout = onehot(w_x);
                        Ain  = 1'b1;
                    end
`ifdef CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        if (Gnz) begin
                            Rout = onehot(w_y);
                            Rin  = onehot(w_x);
                        end else begin
                            Rout = {NREG{1'b0}};
                            Rin  = {NREG{1'b0}};
                        end
                        Done = 1'b1;
                    end
`endif
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                Rout   = onehot(w_y);
                Gin    = 1'b1;
                AddSub = w_op[0];
            end
            T3: begin
                Gout = 1'b1;
                Rin  = onehot(w_x);
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm: a small datapath (R0-R7, A, G, bus)
// driven by the DUT, checked against an architectural register model.
module tb_proc_ctrl_fsm;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Run;
    logic [8:0]  IR;
    logic        Gnz;
    logic        IRin, Gout, DINout, Ain, Gin, AddSub, Done, Busy;
    logic [7:0]  Rin, Rout;

    logic [15:0] din;
    logic [15:0] bus;
    logic [15:0] R [8];
    logic [15:0] A, G;
    logic [15:0] m [8];
    int          errors = 0;
    int          checks = 0;

    always #5 Clock = ~Clock;

    proc_ctrl_fsm dut (
        .Clock (Clock),  .Resetn(Resetn), .Run   (Run),    .IR  (IR),
        .Gnz   (Gnz),    .IRin  (IRin),   .Rin   (Rin),    .Rout(Rout),
        .Gout  (Gout),   .DINout(DINout), .Ain   (Ain),    .Gin (Gin),
        .AddSub(AddSub), .Done  (Done),   .Busy  (Busy)
    );

    // bench datapath: shared bus mux
    always_comb begin
        bus = 16'h0000;
        if (DINout) bus = din;
        else if (Gout) bus = G;
        else for (int i = 0; i < 8; i++) if (Rout[i]) bus = R[i];
    end

    // bench datapath: registers, A and the adder/subtractor into G
    always @(posedge Clock) begin
        for (int i = 0; i < 8; i++) if (Rin[i]) R[i] <= bus;
        if (Ain) A <= bus;
        if (Gin) G <= AddSub ? (A - bus) : (A + bus);
    end

    // Precondition: at a negedge whose next step is T0. Executes one instruction
    // and returns at the negedge of its Done cycle with Run = hold_run.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] x,
                             input logic [2:0] y, input logic [15:0] d,
                             input logic g, input logic hold_run);
        int          lat;
        int          cyc;
        int          bad;
        logic        wr;
        logic        ok;
        logic        exp_done;
        int          srcs;
        logic [15:0] exp_val;
        @(posedge Clock); @(negedge Clock);
        // architectural state left by the previous instruction
        bad = 0;
        for (int i = 0; i < 8; i++) if (R[i] !== m[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL regfile: %0d registers differ, R%0d=%h required %h", bad, x, R[x], m[x]);
        end
        IR = {op, x, y}; din = d; Gnz = g; Run = 1'b1;
        #1;
        checks++;
        if (IRin !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL t0_fetch: IRin=%b Busy=%b Done=%b required 1 0 0", IRin, Busy, Done);
        end
        // architectural effect from the instruction set definition
        lat = (op == 3'b010 || op == 3'b011) ? 4 : 2;
        wr = 1'b1;
        exp_val = 16'h0000;
        case (op)
            3'b000: exp_val = m[y];
            3'b001: exp_val = d;
            3'b010: exp_val = m[x] + m[y];
            3'b011: exp_val = m[x] - m[y];
`ifdef CTRL_MVNZ_EN
            3'b110: begin wr = g; exp_val = m[y]; end
`endif
            default: wr = 1'b0;
        endcase
        cyc = 0;
        do begin
            @(posedge Clock); @(negedge Clock);
            cyc++;
            srcs = $countones(Rout) + int'(Gout) + int'(DINout);
            checks++;
            if (srcs > 1 || $countones(Rin) > 1 || Busy !== 1'b1 || IRin !== 1'b0) begin
                errors++;
                $display("FAIL step_invariant: cyc=%0d srcs=%0d Rin=%h Busy=%b IRin=%b required <=1 onehot 1 0",
                         cyc, srcs, Rin, Busy, IRin);
            end
            exp_done = (cyc == lat - 1);
            checks++;
            if (Done !== exp_done) begin
                errors++;
                $display("FAIL done_timing: op=%b cyc=%0d Done=%b required %b", op, cyc, Done, exp_done);
            end
            if (lat == 4) begin
                case (cyc)
                    1: ok = (bus === m[x]) && (Ain === 1'b1) && (Gin === 1'b0) && (Rin === 8'h00);
                    2: ok = (bus === m[y]) && (Gin === 1'b1) && (Ain === 1'b0) &&
                            (AddSub === op[0]) && (Rin === 8'h00);
                    default: ok = (bus === exp_val) && (Rin === (8'h01 << x)) && (Gout === 1'b1) &&
                                  (Ain === 1'b0) && (Gin === 1'b0);
                endcase
            end else begin
                ok = (Rin === (wr ? (8'h01 << x) : 8'h00)) && (!wr || bus === exp_val) &&
                     (wr || (Rout === 8'h00 && DINout === 1'b0)) &&
                     (Ain === 1'b0) && (Gin === 1'b0) && (Gout === 1'b0);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL step_controls: op=%b x=%0d y=%0d cyc=%0d bus=%h Rin=%h Rout=%h Ain=%b Gin=%b AddSub=%b required bus=%h",
                         op, x, y, cyc, bus, Rin, Rout, Ain, Gin, AddSub, exp_val);
            end
            Run = (Done === 1'b1) ? hold_run : 1'($urandom_range(0, 1));
        end while (Done !== 1'b1 && cyc < 4);
        if (wr) m[x] = exp_val;
    endtask

    // Precondition: at a negedge whose next step is T0. Idles n cycles.
    task automatic idle(input int n);
        Run = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge Clock); @(negedge Clock);
            checks++;
            if ({IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done, Busy} !== 24'd0) begin
                errors++;
                $display("FAIL idle_zero: IRin=%b Rin=%h Rout=%h Done=%b Busy=%b required all 0",
                         IRin, Rin, Rout, Done, Busy);
            end
        end
    endtask

    task automatic test_reset;
        Resetn = 1'b0; Run = 1'b1; IR = 9'h000; din = 16'h0000; Gnz = 1'b0;
        #1;
        checks++;
        if ({IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done, Busy} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs: IRin=%b Busy=%b required 0 0", IRin, Busy);
        end
        @(negedge Clock); @(negedge Clock);
        Resetn = 1'b1; Run = 1'b0;
        idle(2);
    endtask

    task automatic test_init_regs;
        for (int i = 0; i < 8; i++)
            run_instr(3'b001, 3'(i), 3'd0, 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_directed;
        run_instr(3'b001, 3'd0, 3'd0, 16'h0005, 1'b0, 1'b0);   // mvi R0,#5
        run_instr(3'b000, 3'd3, 3'd0, 16'h0000, 1'b0, 1'b0);   // mv R3,R0
        run_instr(3'b010, 3'd0, 3'd3, 16'h0000, 1'b0, 1'b0);   // add R0,R3
        idle(1);
        checks++;
        if (R[0] !== 16'd10 || R[3] !== 16'd5) begin
            errors++;
            $display("FAIL add_result: R0=%h R3=%h required 000a 0005", R[0], R[3]);
        end
        run_instr(3'b011, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0);   // sub R0,R0
        idle(1);
        checks++;
        if (R[0] !== 16'd0) begin
            errors++;
            $display("FAIL sub_self: R0=%h required 0000", R[0]);
        end
        run_instr(3'b010, 3'd3, 3'd3, 16'h0000, 1'b0, 1'b0);   // add R3,R3 doubles R3
        idle(1);
        checks++;
        if (R[3] !== 16'd10) begin
            errors++;
            $display("FAIL add_double: R3=%h required 000a", R[3]);
        end
    endtask

    task automatic test_reset_mid;
        @(posedge Clock); @(negedge Clock);
        IR = {3'b010, 3'd1, 3'd2}; Run = 1'b1;
        @(posedge Clock); @(negedge Clock);   // T1
        @(posedge Clock); @(negedge Clock);   // T2
        Resetn = 1'b0;
        #1;
        checks++;
        if ({IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done, Busy} !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid: Gin=%b Rout=%h Busy=%b IRin=%b required all 0", Gin, Rout, Busy, IRin);
        end
        @(posedge Clock); @(negedge Clock);
        checks++;
        if ({IRin, Busy, Rin} !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold: IRin=%b Busy=%b Rin=%h required 0 0 00", IRin, Busy, Rin);
        end
        Run = 1'b0; Resetn = 1'b1;
        idle(2);
    endtask

    task automatic test_op110;
        run_instr(3'b110, 3'd4, 3'd5, 16'h0000, 1'b1, 1'b0);
        run_instr(3'b110, 3'd6, 3'd7, 16'h0000, 1'b0, 1'b0);
        run_instr(3'b110, 3'd2, 3'd1, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            run_instr(3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
                      1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    task automatic test_back_to_back;
        run_instr(3'b001, 3'd5, 3'd0, 16'h1234, 1'b0, 1'b1);   // mvi R5
        run_instr(3'b011, 3'd5, 3'd2, 16'h0000, 1'b0, 1'b1);   // sub R5,R2
        run_instr(3'b001, 3'd6, 3'd0, 16'hbeef, 1'b0, 1'b1);   // mvi R6
        run_instr(3'b010, 3'd6, 3'd5, 16'h0000, 1'b0, 1'b0);   // add R6,R5
        idle(1);
        checks++;
        if (R[6] !== m[6] || R[5] !== m[5]) begin
            errors++;
            $display("FAIL back_to_back: R5=%h R6=%h required %h %h", R[5], R[6], m[5], m[6]);
        end
    endtask

    initial begin
        test_reset();
        test_init_regs();
        test_directed();
        test_reset_mid();
        test_op110();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
